modport_ram: RTL and testbench

Parameterised simple dual-port synchronous RAM with one write port and one read port sharing a single clock. It is the storage element exercised by the layered counter/memory testbench environment through the `mem_intf` interface. Writes and reads may occur in the same cycle at independent addresses. Read data is registered.

---
 rtl/modport_ram.sv | 60 ++++++
 tb/tb_modport_ram.sv | 127 ++++++++++++
 2 files changed

// File: rtl/modport_ram.sv
// Simple dual-port RAM, reset-clearable, registered read (1-cycle latency), no backpressure.
// Define MODPORT_RAM_WR_BYPASS_EN for write-first same-address collisions (default read-first).
module modport_ram #(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enbl,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_enbl,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;
  logic [DWIDTH-1:0] rd_data_d;
  logic              wr_ok;
  logic              rd_ok;

  // Addresses at or above DEPTH exist only for non-power-of-two depths.
  assign wr_ok = wr_enbl && (int'(wr_addr) < DEPTH);
  assign rd_ok = int'(rd_addr) < DEPTH;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_enbl) begin
      if (rd_ok) begin
        rd_data_d = mem_q[rd_addr];
      end else begin
        rd_data_d = '0;
      end
`ifdef MODPORT_RAM_WR_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_modport_ram.sv
// Directed bench for modport_ram: driver queues expected rd_data, monitor pops and compares.
module tb_modport_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_enbl;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_enbl;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  logic       chk_en;
  logic [7:0] exp_q [$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  modport_ram dut (
    .clk     (clk),
    .rst     (rst),
    .wr_enbl (wr_enbl),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_enbl (rd_enbl),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // One cycle of stimulus, driven 1 unit after the edge; chk queues the value
  // rd_data must hold after the next edge.
  task automatic cycle(input logic r, input logic we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic re, input logic [3:0] ra,
                       input logic chk, input logic [7:0] exp);
    @(posedge clk);
    #1;
    rst     = r;
    wr_enbl = we;
    wr_addr = wa;
    wr_data = wd;
    rd_enbl = re;
    rd_addr = ra;
    chk_en  = chk;
    if (chk) exp_q.push_back(exp);
  endtask

  // Monitor: for a cycle flagged at edge N, sample 1 unit before edge N+1.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (chk_en) begin
        #9;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: rd_data=%h with no expected entry", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            bad++;
            $display("FAIL rd_data at %0t: got %h expected %h", $time, rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] coll_exp;
    rst = 1'b0; wr_enbl = 1'b0; wr_addr = '0; wr_data = '0;
    rd_enbl = 1'b0; rd_addr = '0; chk_en = 1'b0;

    // reset: rd_data cleared after each reset edge
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00);
    for (int a = 0; a < 16; a++)
      cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b1, 8'h00);

    // basic write/read then hold
    cycle(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 1'b1, 8'hA5);

    // full sweep: addr*17 = {addr,addr}
    for (int a = 0; a < 16; a++)
      cycle(1'b1, 1'b1, 4'(a), {4'(a), 4'(a)}, 1'b0, 4'd0, 1'b0, 8'h00);
    for (int a = 0; a < 16; a++)
      cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b1, {4'(a), 4'(a)});

    // same-address collision
`ifdef MODPORT_RAM_WR_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    cycle(1'b1, 1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 4'd7, 1'b1, coll_exp);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 8'h22);

    // independent concurrent access
    cycle(1'b1, 1'b1, 4'd9, 8'h3C, 1'b0, 4'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 4'd2, 8'h5A, 1'b1, 4'd9, 1'b1, 8'h3C);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 8'h5A);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'hFF);

    // mid-operation reset drops the write and clears memory
    cycle(1'b0, 1'b1, 4'd4, 8'hFF, 1'b1, 4'd15, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'h00);

    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
